// File: rtl/lsu_dmem_master.sv
// Load/store initiator: B/H/W accesses become full-word memory ops (sub-word store = read-modify-write).
// Latency fault 1 / load 2 / SW 2 / SB,SH 3 cycles; one request in flight, req_ready only in IDLE.
module lsu_dmem_master #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic        mem_memwrite,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata
);

  localparam logic [31:0] LAST_WORD = 32'(DEPTH - 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE_RD,
    S_WRITE,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        fault_q;
  logic [31:0] addr_q;

  logic        accept;
  logic        req_fault;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = req_valid && (state_q == S_IDLE);

  always_comb begin
    req_fault = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: req_fault = 1'b0;
      3'b001, 3'b101: req_fault = req_addr[0];
      3'b010:         req_fault = (req_addr[1:0] != 2'b00);
      default:        req_fault = 1'b1;
    endcase
    // Unsigned variants only exist for loads
    if (req_write && req_funct3[2]) req_fault = 1'b1;
    if ({req_addr[31:2], 2'b00} > LAST_WORD) req_fault = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_fault)                 state_d = S_RESP;
          else if (!req_write)           state_d = S_LOAD;
          else if (req_funct3 == 3'b010) state_d = S_WRITE;
          else                           state_d = S_STORE_RD;
        end
      end
      S_LOAD:     state_d = S_RESP;
      S_STORE_RD: state_d = S_WRITE;
      S_WRITE:    state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == S_IDLE);
    resp_valid    = (state_q == S_RESP);
    mem_memwrite  = (state_q == S_WRITE);
    mem_writedata = (state_q == S_WRITE) ? word_q : 32'd0;
    resp_rdata    = rdata_q;
    resp_fault    = fault_q;
    mem_address   = addr_q;
  end

  always_comb begin
    byte_lane = mem_readdata[{req_q.lane, 3'b000} +: 8];
    half_lane = mem_readdata[{req_q.lane[1], 4'b0000} +: 16];
    case (req_q.funct3)
      3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b100:  load_ext = {24'd0, byte_lane};
      3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b101:  load_ext = {16'd0, half_lane};
      default: load_ext = mem_readdata;
    endcase
  end

  always_comb begin
    merged = mem_readdata;
    if (req_q.funct3[0]) merged[{req_q.lane[1], 4'b0000} +: 16] = req_q.wdata;
    else                 merged[{req_q.lane, 3'b000} +: 8]      = req_q.wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
      addr_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            req_q.funct3 <= req_funct3;
            req_q.lane   <= req_addr[1:0];
            req_q.wdata  <= req_wdata[15:0];
            word_q       <= req_wdata;
            rdata_q      <= 32'd0;
            fault_q      <= req_fault;
            // Rejected requests leave the memory-side address untouched
            if (!req_fault) addr_q <= {req_addr[31:2], 2'b00};
          end
        end
        S_LOAD:     rdata_q <= load_ext;
        S_STORE_RD: word_q  <= merged;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master with a word-array memory and a response scoreboard.
module tb_lsu_dmem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_address;
  logic        mem_memwrite;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  logic [31:0] mem [4];
  int cyc = 0;
  int wr_cnt = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  lsu_dmem_master #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_memwrite(mem_memwrite),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  assign mem_readdata = mem[mem_address[3:2]];
  always @(posedge clk) if (mem_memwrite) mem[mem_address[3:2]] <= mem_writedata;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_memwrite) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_rdata"}, resp_rdata, e.rdata);
        check({e.tag, "_fault"}, {31'd0, resp_fault}, {31'd0, e.fault});
        check({e.tag, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ef, input int lat,
                        input bit hold, input bit expect_resp, output int e0);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, {31'd0, req_ready}, 32'd1);
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    if (expect_resp) sb.push_back('{tag, er, ef, e0 + lat - 1});
    check({tag, "_ready_low"}, {31'd0, req_ready}, 32'd0);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, e1, e2, wr0;
    mem[0] <= 32'd0;
    mem[1] <= 32'd0;
    mem[2] <= 32'h11223344;
    mem[3] <= 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ready",     {31'd0, req_ready}, 32'd1);
    check("rst_resp_vld",  {31'd0, resp_valid}, 32'd0);
    check("rst_rdata",     resp_rdata, 32'd0);
    check("rst_fault",     {31'd0, resp_fault}, 32'd0);
    check("rst_addr",      mem_address, 32'd0);
    check("rst_memwrite",  {31'd0, mem_memwrite}, 32'd0);
    check("rst_writedata", mem_writedata, 32'd0);
    rst_n = 1'b1;

    // Word round-trip
    do_req("sw4", 1'b1, 3'b010, 32'h4, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1'b0, 1'b1, e0);
    drain();
    check("mem1_sw", mem[1], 32'hDEADBEEF);
    do_req("lw4", 1'b0, 3'b010, 32'h4, 32'd0, 32'hDEADBEEF, 1'b0, 2, 1'b0, 1'b1, e0);
    drain();

    // Byte read-modify-write and sign/zero extension
    wr0 = wr_cnt;
    do_req("sb9", 1'b1, 3'b000, 32'h9, 32'h555555AA, 32'd0, 1'b0, 3, 1'b0, 1'b1, e0);
    drain();
    check("mem2_sb", mem[2], 32'h1122AA44);
    check("sb_one_write", wr_cnt - wr0, 32'd1);
    do_req("lb9",  1'b0, 3'b000, 32'h9, 32'd0, 32'hFFFFFFAA, 1'b0, 2, 1'b0, 1'b1, e0);
    do_req("lbu9", 1'b0, 3'b100, 32'h9, 32'd0, 32'h000000AA, 1'b0, 2, 1'b0, 1'b1, e0);
    do_req("lb8",  1'b0, 3'b000, 32'h8, 32'd0, 32'h00000044, 1'b0, 2, 1'b0, 1'b1, e0);
    do_req("lha",  1'b0, 3'b001, 32'hA, 32'd0, 32'h00001122, 1'b0, 2, 1'b0, 1'b1, e0);
    drain();

    // Halfword store into upper lane
    do_req("she", 1'b1, 3'b001, 32'hE, 32'h12348001, 32'd0, 1'b0, 3, 1'b0, 1'b1, e0);
    drain();
    check("mem3_sh", mem[3], 32'h80010000);
    do_req("lhe",  1'b0, 3'b001, 32'hE, 32'd0, 32'hFFFF8001, 1'b0, 2, 1'b0, 1'b1, e0);
    do_req("lhue", 1'b0, 3'b101, 32'hE, 32'd0, 32'h00008001, 1'b0, 2, 1'b0, 1'b1, e0);
    drain();

    // Faults never touch memory
    wr0 = wr_cnt;
    do_req("f_lw2",   1'b0, 3'b010, 32'h2,  32'd0, 32'd0, 1'b1, 1, 1'b0, 1'b1, e0);
    do_req("f_lh3",   1'b0, 3'b001, 32'h3,  32'd0, 32'd0, 1'b1, 1, 1'b0, 1'b1, e0);
    do_req("f_sw10",  1'b1, 3'b010, 32'h10, 32'hFFFFFFFF, 32'd0, 1'b1, 1, 1'b0, 1'b1, e0);
    do_req("f_f011",  1'b0, 3'b011, 32'h0,  32'd0, 32'd0, 1'b1, 1, 1'b0, 1'b1, e0);
    do_req("f_st100", 1'b1, 3'b100, 32'h0,  32'hFFFFFFFF, 32'd0, 1'b1, 1, 1'b0, 1'b1, e0);
    drain();
    check("fault_no_write", wr_cnt - wr0, 32'd0);
    check("fault_mem0", mem[0], 32'd0);

    // req_valid held high across three requests
    do_req("h_sw0", 1'b1, 3'b010, 32'h0, 32'h01020304, 32'd0, 1'b0, 2, 1'b1, 1'b1, e0);
    do_req("h_sb1", 1'b1, 3'b000, 32'h1, 32'h00000077, 32'd0, 1'b0, 3, 1'b1, 1'b1, e1);
    do_req("h_lw0", 1'b0, 3'b010, 32'h0, 32'd0, 32'h01027704, 1'b0, 2, 1'b0, 1'b1, e2);
    drain();
    check("spacing_sw", e1 - e0, 32'd3);
    check("spacing_sb", e2 - e1, 32'd4);

    // Reset during STORE_RD aborts the sub-word store
    wr0 = wr_cnt;
    do_req("rst_sb8", 1'b1, 3'b000, 32'h8, 32'h000000CC, 32'd0, 1'b0, 3, 1'b0, 1'b0, e0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_memwrite",  {31'd0, mem_memwrite}, 32'd0);
    check("abort_writedata", mem_writedata, 32'd0);
    check("abort_ready",     {31'd0, req_ready}, 32'd1);
    check("abort_resp_vld",  {31'd0, resp_valid}, 32'd0);
    check("abort_addr",      mem_address, 32'd0);
    check("abort_rdata",     resp_rdata, 32'd0);
    check("abort_fault",     {31'd0, resp_fault}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_write", wr_cnt - wr0, 32'd0);
    check("abort_mem2", mem[2], 32'h1122AA44);

    do_req("post_lw8", 1'b0, 3'b010, 32'h8, 32'd0, 32'h1122AA44, 1'b0, 2, 1'b0, 1'b1, e0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_master.md
# lsu_dmem_master

Load/store unit that acts as the initiator on the data-memory port. It accepts one load or store request at a time from the core's execute stage and translates RISC-V byte, halfword and word accesses into full-word memory operations. It handles sub-word stores by read-modify-write, performs sign or zero extension on loads, and returns a single-cycle response carrying data or a fault. It sits between the core datapath and the byte-addressed, 32-bit-port data memory: combinational read, write on posedge when the write strobe is high.

## Interface
- `DEPTH`, 16: data memory size in bytes; must be a multiple of 4.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the block can accept a request; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: access size, RISC-V encoding. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; the low byte or halfword is used for sub-word stores.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and for faults.
- `resp_fault` out 1: the request was rejected; qualified by `resp_valid`.
- `mem_address` out 32: word-aligned address sent to memory.
- `mem_memwrite` out 1: memory write strobe.
- `mem_writedata` out 32: full word to write.
- `mem_readdata` in 32: combinational read data from memory.

## Operation
- **Accept.** A request is accepted on a rising edge where `req_valid` and `req_ready` are both high. On acceptance the block latches write, funct3, address and wdata.
- **Fault check at acceptance.** A request faults if any of these holds:
  - funct3 is 011, 110 or 111;
  - it is a store with funct3 100 or 101;
  - it is a halfword access with `addr[0]` = 1;
  - it is a word access with `addr[1:0]` ≠ 00;
  - `{addr[31:2],2'b00}` > DEPTH−4.
- **Faulting requests** go directly to RESP and never touch memory.
- **States:**
  - IDLE: accept a request and go to LOAD, STORE_RD, WRITE (store word) or RESP (fault).
  - LOAD: capture `mem_readdata`, select the lane, extend the result into `resp_rdata`; go to RESP.
  - STORE_RD: capture `mem_readdata` and merge the wdata byte or halfword into the selected lane; go to WRITE.
  - WRITE: assert `mem_memwrite` with the merged word (or the full wdata for SW); go to RESP.
  - RESP: assert `resp_valid`; go to IDLE.
- **Lane selection.** Byte lane is `addr[1:0]`. Halfword lane is `addr[1]`: bits [15:0] or [31:16]. Memory byte `addr` maps to bits [7:0] of the lane.
- **Extension.** B and H sign-extend from bit 7 and bit 15 respectively. BU and HU zero-extend. W passes through unchanged.
- **Sub-word stores preserve** all untouched bytes of the word.
- **Memory-side outputs.**
  - `mem_address` = registered `{addr[31:2],2'b00}` of the latched request; it holds its value outside of accesses.
  - `mem_memwrite` is high only in WRITE and is decoded from the state register, so it is glitch-free.
  - `mem_writedata` is 0 except in WRITE.
- **Reset values.** IDLE state, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, `mem_address`=0, `mem_memwrite`=0, `mem_writedata`=0, internal registers 0.
- **Reset mid-operation.** Asserting `rst_n` low aborts the access immediately. `mem_memwrite` drops asynchronously, so no write occurs on the next edge. No response is issued.

## Timing
- Let E0 be the acceptance edge.
- **Latencies:**
  - Fault: RESP occupies the cycle after E0, so `resp_valid` is high in cycle E0+1.
  - Load: LOAD in E0+1, `resp_valid` in E0+2.
  - Store word: WRITE in E0+1, memory written at the end of E0+1, `resp_valid` in E0+2.
  - Sub-word store: STORE_RD in E0+1, WRITE in E0+2, `resp_valid` in E0+3.
- `req_ready` is low from E0+1 until the cycle after RESP.
- Back-to-back throughput is therefore one request every 3, 3 or 4 cycles for load, store word and sub-word store respectively.
- `req_valid` asserted while `req_ready` is low is ignored. The request must be held by the requester.
- The response outputs hold their values only while `resp_valid` is high. After that they are don't-care, except that they read 0 after reset.
- A load issued immediately after a store to the same word observes the stored data, because the write completes before the LOAD state.

## Test plan
- **Word round-trip.** SW 0xDEADBEEF @0x4, then LW @0x4 → `resp_rdata`=0xDEADBEEF, fault=0, `resp_valid` 2 cycles after each acceptance.
- **Byte RMW.** Mem word @0x8 = 0x11223344; SB wdata 0xAA @0x9 → word becomes 0x1122AA44, and `mem_memwrite` is high for exactly one cycle. Then LB @0x9 → 0xFFFFFFAA, and LBU @0x9 → 0x000000AA.
- **Halfword.** SH 0x8001 @0xE into 0x00000000 → word 0x80010000. Then LH @0xE → 0xFFFF8001, and LHU @0xE → 0x00008001.
- **Faults.** Each of the following gives `resp_fault`=1, `resp_rdata`=0, `resp_valid` one cycle after acceptance, and `mem_memwrite` never asserted:
  - LW @0x2;
  - LH @0x3;
  - SW @0x10 with DEPTH=16;
  - funct3 011;
  - store with funct3 100.
- **Handshake.** Hold `req_valid` high continuously across three requests → each is accepted only when `req_ready`=1, and the `resp_valid` pulses are spaced according to the latencies above.
- **Reset mid-store.** Drop `rst_n` during STORE_RD of an SB → no memory write, no `resp_valid`, all outputs at their reset values, and the memory word is unchanged.
